// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the ALU control sequencer and its arbiter:
// opcode encodings, sequencer state type and response flag bit positions.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } alu_ctrl_state_t;

  // Bit positions inside the 3-bit response flag word {great, less, eq}.
  localparam int unsigned FLAG_EQ    = 0;
  localparam int unsigned FLAG_LESS  = 1;
  localparam int unsigned FLAG_GREAT = 2;

endpackage

// File: rtl/alu_ctrl_arbiter_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. Grant is combinational from the valid
// bits and the priority pointer; the pointer moves to the other requester on
// every accepted grant.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req_valid  per-requester valid
//   accept     high when the current grant is being taken this cycle
//   grant      one-hot (or zero) grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // grant[1] is the granted index; priority passes to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~grant[1];
    end
  end

endmodule

// File: rtl/alu_ctrl_arbiter.sv
// alu_ctrl_arbiter
// Sequencer for the clockless 4-bit ALU datapath. Accepts requests from two
// requesters (round-robin), drives the ALU for one execute cycle, captures
// the datapath outputs and returns a tagged response on one channel.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (bit i = requester i)
//   req{0,1}_op/_a/_b        opcode and operands per requester
//   rsp_valid / rsp_ready    response handshake
//   rsp_id/rsp_data/rsp_flags response owner, result, {great, less, eq}
//   busy                     state is not idle
//   alu_sel/alu_a/alu_b      datapath drive, zero outside the execute cycle
//   alu_result/alu_answer/alu_eq/alu_less/alu_great  datapath outputs
module alu_ctrl_arbiter
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [4:0] rsp_data,
  output logic [2:0] rsp_flags,
  output logic       busy,
  output logic [1:0] alu_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [4:0] alu_result,
  input  logic [3:0] alu_answer,
  input  logic       alu_eq,
  input  logic       alu_less,
  input  logic       alu_great
);

  alu_ctrl_state_t state_q, state_d;
  logic [1:0] grant;
  logic       accept;
  logic [1:0] op_q;
  logic [3:0] a_q, b_q;
  logic       id_q;
  logic [4:0] rsp_data_q, cap_data;
  logic [2:0] rsp_flags_q, cap_flags;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant)
  );

  // Ready depends combinationally on valid through the grant.
  assign req_ready = (state_q == StIdle) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_ADD;
      a_q  <= 4'h0;
      b_q  <= 4'h0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= grant[1] ? req1_op : req0_op;
      a_q  <= grant[1] ? req1_a  : req0_a;
      b_q  <= grant[1] ? req1_b  : req0_b;
      id_q <= grant[1];
    end
  end

  // Select the datapath output relevant to the latched opcode.
  always_comb begin
    cap_data  = 5'h00;
    cap_flags = 3'b000;
    unique case (op_q)
      OP_ADD, OP_SUB: cap_data = alu_result;
      OP_CMP: begin
        cap_flags[FLAG_GREAT] = alu_great;
        cap_flags[FLAG_LESS]  = alu_less;
        cap_flags[FLAG_EQ]    = alu_eq;
      end
      OP_AND:  cap_data = {1'b0, alu_answer};
      default: cap_data = 5'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q  <= 5'h00;
      rsp_flags_q <= 3'b000;
    end else if (state_q == StExec) begin
      rsp_data_q  <= cap_data;
      rsp_flags_q <= cap_flags;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (state_q != StIdle);

  // Datapath held quiescent except during the execute cycle.
  assign alu_sel = (state_q == StExec) ? op_q : 2'b00;
  assign alu_a   = (state_q == StExec) ? a_q  : 4'h0;
  assign alu_b   = (state_q == StExec) ? b_q  : 4'h0;

endmodule

// File: tb/tb_alu_ctrl_arbiter.sv
// tb_alu_ctrl_arbiter
// Self-checking bench: behavioural ALU datapath, directed and randomized
// operations, backpressure, round-robin ordering and mid-operation reset.
module tb_alu_ctrl_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [4:0] rsp_data;
  logic [2:0] rsp_flags;
  logic [1:0] alu_sel;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_result;
  logic [3:0] alu_answer;
  logic       alu_eq, alu_less, alu_great;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .busy       (busy),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_answer (alu_answer),
    .alu_eq     (alu_eq),
    .alu_less   (alu_less),
    .alu_great  (alu_great)
  );

  // Behavioural model of the clockless datapath.
  assign alu_result = (alu_sel == 2'b01) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1)
                                         : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_answer = alu_a & alu_b;
  assign alu_eq     = (alu_a == alu_b);
  assign alu_less   = (alu_a < alu_b);
  assign alu_great  = (alu_a > alu_b);

  // Reference results straight from the arithmetic meaning of each opcode.
  function automatic logic [4:0] ref_data(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = (int'(a) + 16 - int'(b)) % 32;  // bit 4 set when no borrow
      2'd2:    r = 0;
      default: r = int'(a) & int'(b);
    endcase
    return r[4:0];
  endfunction

  function automatic logic [2:0] ref_flags(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    if (op != 2'd2) return 3'b000;
    return {a > b, a < b, a == b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_alu"},       {20'd0, alu_sel, alu_a, alu_b}, 32'd0);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_op(input int id, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int stall);
    logic [4:0] ed;
    logic [2:0] ef;
    ed = ref_data(op, a, b);
    ef = ref_flags(op, a, b);
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req_valid = 2'b01;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req_valid = 2'b10;
    end
    rsp_ready = 1'b0;
    #1;
    chk("ready_in_idle", 32'(req_ready), 32'(req_valid));
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("exec_busy",      32'(busy),      32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_alu",       {20'd0, alu_sel, alu_a, alu_b}, {20'd0, op, a, b});
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_fields", {23'd0, rsp_id, rsp_data, rsp_flags}, {23'd0, id[0], ed, ef});
    chk("resp_alu_quiet", {20'd0, alu_sel, alu_a, alu_b}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      req_valid = 2'b11;
      @(posedge clk); #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_fields", {23'd0, rsp_id, rsp_data, rsp_flags}, {23'd0, id[0], ed, ef});
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_busy",      32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_q[$];
    logic [8:0] front;
    int         n_acc, n_rsp, idx, renew, cycles;

    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_op = 2'd0; req0_a = 4'h0; req0_b = 4'h0;
    req1_op = 2'd0; req1_a = 4'h0; req1_b = 4'h0;

    // Reset, then idle.
    do_reset();
    chk_quiet_outputs("reset");
    @(posedge clk); #1;
    chk_quiet_outputs("idle");

    // Directed operations.
    run_op(0, 2'd0, 4'h9, 4'h8, 0);  // 9+8 -> 11
    run_op(1, 2'd1, 4'h5, 4'h7, 0);  // 5-7 -> 0E
    run_op(1, 2'd1, 4'h7, 4'h5, 0);  // 7-5 -> 12
    run_op(0, 2'd2, 4'h3, 4'h9, 0);  // flags 010
    run_op(1, 2'd3, 4'hC, 4'hA, 0);  // 08
    run_op(0, 2'd2, 4'h6, 4'h6, 0);
    run_op(1, 2'd2, 4'hF, 4'h0, 0);
    run_op(0, 2'd0, 4'hF, 4'hF, 5);  // backpressure for 5 cycles
    run_op(1, 2'd1, 4'h0, 4'h0, 1);

    // Randomized operations with random owner and random backpressure.
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end

    // Reset while in EXEC drops the operation.
    req0_op = 2'd0; req0_a = 4'h3; req0_b = 4'h4; req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("pre_reset_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_quiet_outputs("reset_in_exec");
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_no_rsp", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    // Both requesters valid continuously from reset: grants alternate 0,1,...
    do_reset();
    req0_op = 2'($urandom_range(0, 3)); req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_op = 2'($urandom_range(0, 3)); req1_a = 4'($urandom); req1_b = 4'($urandom);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    renew = -1;
    cycles = 0;
    #1;
    while ((n_acc < 6 || n_rsp < 6) && cycles < 80) begin
      if (renew == 0) begin
        req0_op = 2'($urandom_range(0, 3)); req0_a = 4'($urandom); req0_b = 4'($urandom);
      end else if (renew == 1) begin
        req1_op = 2'($urandom_range(0, 3)); req1_a = 4'($urandom); req1_b = 4'($urandom);
      end
      renew = -1;
      if (n_acc >= 6) req_valid = 2'b00;
      #1;
      chk("ready_not_both", 32'(req_ready == 2'b11), 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rr_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          front = exp_q.pop_front();
          chk("rr_rsp", {23'd0, rsp_id, rsp_data, rsp_flags}, {23'd0, front});
        end
        n_rsp++;
      end
      if (req_ready != 2'b00) begin
        idx = req_ready[1] ? 1 : 0;
        chk("rr_order", 32'(idx), 32'(n_acc % 2));
        if (idx == 0) exp_q.push_back({1'b0, ref_data(req0_op, req0_a, req0_b),
                                       ref_flags(req0_op, req0_a, req0_b)});
        else          exp_q.push_back({1'b1, ref_data(req1_op, req1_a, req1_b),
                                       ref_flags(req1_op, req1_a, req1_b)});
        n_acc++;
        renew = idx;
      end
      @(posedge clk); #1;
      cycles++;
    end
    chk("rr_completed_in_budget", 32'(cycles < 80), 32'd1);
    chk("rr_accepts", 32'(n_acc), 32'd6);
    req_valid = 2'b00;
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
